// File: rtl/maze_nav_ctl_if.sv
// Motor/step command bus between the maze navigator and the wheel drivers.
// master = navigator side, slave = driver side.
interface maze_nav_ctl_if;
  logic        motorL_dir;
  logic        motorR_dir;
  logic [15:0] speedL;
  logic [15:0] speedR;
  logic        speed_en;
  logic        step_en;
  logic [15:0] degreeL;
  logic [15:0] degreeR;
  logic        driver_sel;
  logic        step_done;

  modport master (
    output motorL_dir, motorR_dir,
    output speedL, speedR, speed_en,
    output step_en, degreeL, degreeR,
    output driver_sel,
    input  step_done
  );

  modport slave (
    input  motorL_dir, motorR_dir,
    input  speedL, speedR, speed_en,
    input  step_en, degreeL, degreeR,
    input  driver_sel,
    output step_done
  );
endinterface

// File: rtl/maze_nav_ctl.sv
// Wall-following maze navigator FSM with optional path log.
// Define MAZE_PATH_LOG_EN to build the path log.
module maze_nav_ctl #(
  parameter int          N_SENS     = 8,
  parameter logic [15:0] FWD_SPEED  = 16'd360,
  parameter logic [15:0] ADJ_SPEED  = 16'd180,
  parameter logic [15:0] TURN_DEG_O = 16'd240,
  parameter logic [15:0] TURN_DEG_I = 16'd120,
  parameter logic [15:0] UTURN_DEG  = 16'd360,
  parameter int          PATH_DEPTH = 32,
  localparam int         HALF = N_SENS / 2,
  localparam int         AW   = $clog2(PATH_DEPTH),
  localparam int         SW   = $clog2(HALF + 1)
) (
  input  logic              WF_CLK,
  input  logic              rst_n,
  input  logic              bump_n,
  input  logic              start_n,
  input  logic              hand_sel,
  input  logic [N_SENS-1:0] ir_color,
  maze_nav_ctl_if.master    mot,
  output logic [3:0]        state,
  output logic              done,
  output logic [AW:0]       path_len,
  output logic              path_ovf,
  input  logic [AW-1:0]     path_rd_addr,
  output logic [1:0]        path_rd_data
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SEARCH    = 4'd1,
    FOLLOW    = 4'd2,
    ADJUST    = 4'd3,
    TURN      = 4'd4,
    UTURN     = 4'd5,
    BACKUP    = 4'd6,
    STEP_WAIT = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t st, nxt, ret_q;
  logic   hand_q, sw_first;
  logic   lo_all, hi_all;
  logic   pref, oppo, lost, goal;
  logic   on_track, centered, mirror;
  logic   l_more;
  logic [SW-1:0] lsum, rsum;

  always_comb begin
    lsum   = '0;
    rsum   = '0;
    mirror = 1'b1;
    for (int i = 0; i < HALF; i++) begin
      lsum   = lsum + SW'(ir_color[HALF+i]);
      rsum   = rsum + SW'(ir_color[i]);
      mirror = mirror &
               (ir_color[HALF+i] == ir_color[HALF-1-i]);
    end
  end

  assign lo_all   = &ir_color[HALF-1:0];
  assign hi_all   = &ir_color[N_SENS-1:HALF];
  assign pref     = hand_q ? hi_all : lo_all;
  assign oppo     = hand_q ? lo_all : hi_all;
  assign lost     = ~|ir_color;
  assign goal     = ir_color[0] & ir_color[N_SENS-1]
                  & ~(&ir_color);
  assign on_track = ir_color[HALF-1] | ir_color[HALF];
  assign centered = on_track & mirror;
  assign l_more   = lsum > rsum;
  assign state    = st;

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:   if (!start_n) nxt = SEARCH;
      SEARCH: if (on_track) nxt = FOLLOW;
      FOLLOW: begin
        priority case (1'b1)
          goal:           nxt = DONE;
          pref:           nxt = TURN;
          centered, oppo: nxt = FOLLOW;
          !lost:          nxt = ADJUST;
          default:        nxt = UTURN;
        endcase
      end
      ADJUST: if (lsum == rsum) nxt = FOLLOW;
      TURN, UTURN: nxt = STEP_WAIT;
      STEP_WAIT:
        if (!sw_first && mot.step_done) nxt = ret_q;
      BACKUP: if (lost) nxt = SEARCH;
      DONE:   if (!start_n) nxt = SEARCH;
      default: nxt = IDLE;
    endcase
    if (!bump_n) nxt = IDLE;
  end

  // Outputs are registered from the next state so they line up with st.
  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      st             <= IDLE;
      ret_q          <= FOLLOW;
      hand_q         <= 1'b0;
      sw_first       <= 1'b0;
      done           <= 1'b0;
      mot.motorL_dir <= 1'b0;
      mot.motorR_dir <= 1'b0;
      mot.speedL     <= '0;
      mot.speedR     <= '0;
      mot.speed_en   <= 1'b0;
      mot.step_en    <= 1'b0;
      mot.degreeL    <= '0;
      mot.degreeR    <= '0;
      mot.driver_sel <= 1'b0;
    end else begin
      st       <= nxt;
      sw_first <= (nxt == STEP_WAIT) && (st != STEP_WAIT);
      if (st == IDLE && nxt == SEARCH) hand_q <= hand_sel;
      if (nxt == TURN)  ret_q <= FOLLOW;
      if (nxt == UTURN) ret_q <= BACKUP;
      done           <= (nxt == DONE);
      mot.step_en    <= (nxt == TURN) || (nxt == UTURN);
      mot.driver_sel <= nxt inside {TURN, UTURN, STEP_WAIT};
      mot.speed_en   <= nxt inside {SEARCH, FOLLOW,
                                    ADJUST, BACKUP};
      unique case (nxt)
        SEARCH, FOLLOW: begin
          mot.motorL_dir <= 1'b0;
          mot.motorR_dir <= 1'b0;
          mot.speedL     <= FWD_SPEED;
          mot.speedR     <= FWD_SPEED;
          mot.degreeL    <= '0;
          mot.degreeR    <= '0;
        end
        ADJUST: begin
          mot.motorL_dir <= l_more;
          mot.motorR_dir <= !l_more;
          mot.speedL     <= ADJ_SPEED;
          mot.speedR     <= ADJ_SPEED;
          mot.degreeL    <= '0;
          mot.degreeR    <= '0;
        end
        TURN: begin
          mot.motorL_dir <= hand_q;
          mot.motorR_dir <= !hand_q;
          mot.speedL     <= ADJ_SPEED;
          mot.speedR     <= ADJ_SPEED;
          mot.degreeL    <= hand_q ? TURN_DEG_I : TURN_DEG_O;
          mot.degreeR    <= hand_q ? TURN_DEG_O : TURN_DEG_I;
        end
        UTURN: begin
          mot.motorL_dir <= hand_q;
          mot.motorR_dir <= !hand_q;
          mot.speedL     <= ADJ_SPEED;
          mot.speedR     <= ADJ_SPEED;
          mot.degreeL    <= UTURN_DEG;
          mot.degreeR    <= UTURN_DEG;
        end
        STEP_WAIT: begin
        end
        BACKUP: begin
          mot.motorL_dir <= 1'b1;
          mot.motorR_dir <= 1'b1;
          mot.speedL     <= ADJ_SPEED;
          mot.speedR     <= ADJ_SPEED;
          mot.degreeL    <= '0;
          mot.degreeR    <= '0;
        end
        default: begin
          mot.motorL_dir <= 1'b0;
          mot.motorR_dir <= 1'b0;
          mot.speedL     <= '0;
          mot.speedR     <= '0;
          mot.degreeL    <= '0;
          mot.degreeR    <= '0;
        end
      endcase
    end
  end

`ifdef MAZE_PATH_LOG_EN
  logic [1:0] log_mem [PATH_DEPTH];
  logic       oppo_q, ev, clr, full;
  logic [1:0] ev_code;

  always_comb begin
    ev      = 1'b0;
    ev_code = 2'b00;
    unique case (1'b1)
      nxt == TURN: begin
        ev      = 1'b1;
        ev_code = 2'b01;
      end
      nxt == UTURN: begin
        ev      = 1'b1;
        ev_code = 2'b10;
      end
      st == FOLLOW && nxt == FOLLOW && oppo && !oppo_q: begin
        ev      = 1'b1;
        ev_code = 2'b00;
      end
      default: begin
      end
    endcase
  end

  assign clr  = (nxt == SEARCH) && (st == IDLE || st == DONE);
  assign full = path_len == (AW+1)'(PATH_DEPTH);

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      oppo_q       <= 1'b0;
      path_len     <= '0;
      path_ovf     <= 1'b0;
      path_rd_data <= 2'b00;
    end else begin
      oppo_q       <= oppo;
      path_rd_data <= log_mem[path_rd_addr];
      if (clr) begin
        path_len <= '0;
        path_ovf <= 1'b0;
      end else if (ev) begin
        if (full) path_ovf <= 1'b1;
        else      path_len <= path_len + 1'b1;
      end
    end
  end

  always_ff @(posedge WF_CLK) begin
    if (ev && !clr && !full)
      log_mem[path_len[AW-1:0]] <= ev_code;
  end
`else
  logic unused_rd;
  assign unused_rd    = ^path_rd_addr;
  assign path_len     = '0;
  assign path_ovf     = 1'b0;
  assign path_rd_data = 2'b00;
`endif

endmodule

// File: tb/tb_maze_nav_ctl.sv
// Directed self-checking bench for maze_nav_ctl.
// Log expectations follow MAZE_PATH_LOG_EN.
module tb_maze_nav_ctl;
`ifdef MAZE_PATH_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic       WF_CLK = 1'b0;
  logic       rst_n, bump_n, start_n, hand_sel;
  logic [7:0] ir_color;
  logic [3:0] state;
  logic       done, path_ovf;
  logic [5:0] path_len;
  logic [4:0] path_rd_addr;
  logic [1:0] path_rd_data;
  int         passed = 0;
  int         total  = 0;

  maze_nav_ctl_if mif ();

  maze_nav_ctl dut (
    .WF_CLK       (WF_CLK),
    .rst_n        (rst_n),
    .bump_n       (bump_n),
    .start_n      (start_n),
    .hand_sel     (hand_sel),
    .ir_color     (ir_color),
    .mot          (mif),
    .state        (state),
    .done         (done),
    .path_len     (path_len),
    .path_ovf     (path_ovf),
    .path_rd_addr (path_rd_addr),
    .path_rd_data (path_rd_data)
  );

  always #5 WF_CLK = ~WF_CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge WF_CLK);
    #1;
  endtask

  task automatic chk_turn_r(input string tag);
    chk({tag, "_st"}, state, 4);
    chk({tag, "_sten"}, mif.step_en, 1);
    chk({tag, "_degL"}, mif.degreeL, 240);
    chk({tag, "_degR"}, mif.degreeR, 120);
    chk({tag, "_dirR"}, mif.motorR_dir, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bump_n = 1'b1;
    start_n = 1'b1;
    hand_sel = 1'b0;
    ir_color = 8'h00;
    mif.step_done = 1'b0;
    path_rd_addr = '0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_speed_en", mif.speed_en, 0);
    chk("rst_step_en", mif.step_en, 0);
    chk("rst_done", done, 0);
    chk("rst_len", path_len, 0);
    #20 rst_n = 1'b1;

    ir_color = 8'h18;
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    chk("search_st", state, 1);
    chk("search_spdL", mif.speedL, 360);
    chk("search_spdR", mif.speedR, 360);
    chk("search_en", mif.speed_en, 1);
    step();
    chk("follow_st", state, 2);
    chk("follow_spd", mif.speedL, 360);
    chk("follow_en", mif.speed_en, 1);
    step();
    chk("follow_hold", state, 2);

    ir_color = 8'h0F;
    step();
    chk_turn_r("turn");
    chk("turn_dirL", mif.motorL_dir, 0);
    chk("turn_drv", mif.driver_sel, 1);
    ir_color = 8'h18;
    mif.step_done = 1'b1;
    step();
    chk("sw_st", state, 7);
    chk("sw_sten", mif.step_en, 0);
    chk("sw_dirR", mif.motorR_dir, 1);
    step();
    chk("sw_first_ign", state, 7);
    step();
    mif.step_done = 1'b0;
    chk("turn_ret", state, 2);
    chk("turn_len", path_len, LOG ? 1 : 0);
    path_rd_addr = 5'd0;
    step();
    chk("log0", path_rd_data, LOG ? 2'b01 : 2'b00);

    ir_color = 8'h00;
    step();
    chk("ut_st", state, 5);
    chk("ut_sten", mif.step_en, 1);
    chk("ut_degL", mif.degreeL, 360);
    chk("ut_degR", mif.degreeR, 360);
    chk("ut_dirL", mif.motorL_dir, 0);
    chk("ut_dirR", mif.motorR_dir, 1);
    mif.step_done = 1'b1;
    step();
    chk("ut_sw", state, 7);
    step();
    step();
    mif.step_done = 1'b0;
    chk("bk_st", state, 6);
    chk("bk_dirL", mif.motorL_dir, 1);
    chk("bk_dirR", mif.motorR_dir, 1);
    chk("bk_spd", mif.speedL, 180);
    step();
    chk("bk_search", state, 1);
    path_rd_addr = 5'd1;
    step();
    chk("log1", path_rd_data, LOG ? 2'b10 : 2'b00);

    ir_color = 8'h18;
    step();
    chk("refollow", state, 2);
    ir_color = 8'hF0;
    step();
    chk("oppo_stay", state, 2);
    chk("oppo_len", path_len, LOG ? 3 : 0);
    ir_color = 8'h18;
    step();

    ir_color = 8'h1C;
    step();
    chk("adj_st", state, 3);
    chk("adj_dirL", mif.motorL_dir, 0);
    chk("adj_dirR", mif.motorR_dir, 1);
    chk("adj_spd", mif.speedR, 180);
    ir_color = 8'h18;
    step();
    chk("adj_ret", state, 2);
    ir_color = 8'h38;
    step();
    chk("adj2_dirL", mif.motorL_dir, 1);
    chk("adj2_dirR", mif.motorR_dir, 0);
    ir_color = 8'h18;
    step();

    ir_color = 8'hE1;
    step();
    chk("goal_st", state, 8);
    chk("goal_done", done, 1);
    chk("goal_spd", mif.speedL, 0);
    chk("goal_en", mif.speed_en, 0);
    step();
    chk("goal_hold", state, 8);

    ir_color = 8'h18;
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    chk("restart_st", state, 1);
    chk("restart_len", path_len, 0);
    step();
    for (int i = 0; i < 33; i++) begin
      ir_color = 8'h0F;
      step();
      ir_color = 8'h18;
      mif.step_done = 1'b1;
      step();
      step();
      step();
      mif.step_done = 1'b0;
      if (i == 31) chk("ovf_pre", path_ovf, 0);
    end
    chk("ovf_state", state, 2);
    chk("ovf_len", path_len, LOG ? 32 : 0);
    chk("ovf_flag", path_ovf, LOG ? 1 : 0);
    path_rd_addr = 5'd31;
    step();
    chk("log31", path_rd_data, LOG ? 2'b01 : 2'b00);

    ir_color = 8'h0F;
    step();
    ir_color = 8'h18;
    step();
    chk("bump_sw", state, 7);
    bump_n = 1'b0;
    step();
    bump_n = 1'b1;
    chk("bump_st", state, 0);
    chk("bump_drv", mif.driver_sel, 0);
    chk("bump_en", mif.speed_en, 0);

    hand_sel = 1'b1;
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    step();
    chk("lh_follow", state, 2);
    ir_color = 8'hF0;
    step();
    chk("lh_turn", state, 4);
    chk("lh_degL", mif.degreeL, 120);
    chk("lh_degR", mif.degreeR, 240);
    chk("lh_dirL", mif.motorL_dir, 1);
    chk("lh_dirR", mif.motorR_dir, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("art_state", state, 0);
    chk("art_sten", mif.step_en, 0);
    chk("art_degL", mif.degreeL, 0);
    chk("art_dirL", mif.motorL_dir, 0);
    chk("art_drv", mif.driver_sel, 0);
    chk("art_len", path_len, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
